// File: rtl/mix_column_iter.sv
// rtl/mix_column_iter.sv - column-serial forward AES MixColumns engine
// One shared column mixer rewrites the working state in place, one column per clock.
module mix_column_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   fsm;
    logic [1:0]   col;
    logic [0:127] st;
    logic [0:31]  col_in;
    logic [0:31]  col_out;
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   d0, d1, d2, d3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        col_in = st[{col, 5'b0} +: 32];
        a0 = col_in[0:7];
        a1 = col_in[8:15];
        a2 = col_in[16:23];
        a3 = col_in[24:31];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        // 3*b is folded in as 2*b ^ b
        col_out = {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                   a0 ^ d1 ^ d2 ^ a2 ^ a3,
                   a0 ^ a1 ^ d2 ^ d3 ^ a3,
                   d0 ^ a0 ^ a1 ^ a2 ^ d3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            col <= 2'd0;
            st  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st  <= state;
                        col <= 2'd0;
                        fsm <= BUSY;
                    end
                end
                BUSY: begin
                    st[{col, 5'b0} +: 32] <= col_out;
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign out       = st;

endmodule

// File: tb/tb_mix_column_iter.sv
// tb/tb_mix_column_iter.sv - scoreboard bench for mix_column_iter
// Driver pushes expected results; a negedge monitor pops and checks on each output handshake.
module tb_mix_column_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out;

    typedef struct {
        logic [0:127] exp;
        logic [0:127] orig;
        bit           rt;
        bit           per;
        int           acc;
    } entry_t;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = 0;
    bit prev_ov = 1'b0;

    localparam logic [0:127] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [0:127] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [0:127] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [0:127] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    mix_column_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [0:127] mix_ref(input logic [0:127] s, input bit inv);
        logic [0:127] r;
        logic [7:0]   a[4];
        logic [7:0]   m[4];
        logic [7:0]   acc;
        if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[32*c + 8*i +: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++) acc ^= gf_mul(a[i], m[(i - row) & 3]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [0:127] s, input logic [0:127] e, input bit rt,
                        input bit per, output int waited);
        entry_t ent;
        int n;
        state_in = s;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        waited = n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 want 1 within 20 cycles");
        end else begin
            ent.exp  = e;
            ent.orig = s;
            ent.rt   = rt;
            ent.per  = per;
            ent.acc  = cyc + 1;
            sb.push_back(ent);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 128'd1, 128'd0);
                else chk("latency", 128'(cyc - sb[0].acc), 128'd4);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                entry_t e;
                e = sb.pop_front();
                if (e.rt) chk("round_trip", mix_ref(out, 1'b1), e.orig);
                else      chk("result", out, e.exp);
                if (e.per) chk("period", 128'(cyc - last_hs), 128'd6);
                last_hs = cyc;
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int w;
        logic [0:127] r;
        logic [0:127] v3;

        #2;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out", out, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        out_ready = 1'b1;
        send(V1_IN, V1_OUT, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(V2_IN, V2_OUT, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Backpressure with in_valid held high the whole time
        out_ready = 1'b0;
        v3 = {$urandom, $urandom, $urandom, $urandom};
        send(V2_IN, V2_OUT, 1'b0, 1'b0, w);
        state_in = v3;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out", out, V2_OUT);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(v3, mix_ref(v3, 1'b0), 1'b0, 1'b0, w);
        chk("in_ready_after_hs", 128'(w), 128'd2);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Asynchronous reset during the second BUSY cycle
        send(V1_IN, V1_OUT, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_out", out, 128'd0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(V1_IN, V1_OUT, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, mix_ref(r, 1'b0), 1'b0, i != 0, w);
        end
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, '0, 1'b1, 1'b0, w);
        end
        in_valid = 1'b0;

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("drain", 128'(sb.size()), 128'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("final_idle", 128'(in_ready), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_column_iter.md
# mix_column_iter

Sequential forward AES MixColumns engine: accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock. It returns the mixed state over a second valid/ready handshake. It sits in the encryption round datapath between ShiftRows and AddRoundKey, and is the forward counterpart of the decryption-side inverse MixColumns. Trading the 4x-parallel combinational form for a column-serial one cuts the GF(2^8) multiplier area by four.

## Interface
- No parameters. Data width is fixed at 128 bits, as 4 columns of 4 bytes.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `state` is valid this cycle.
- in_ready  output  1  engine can accept a state.
- state  input  [0:127]  input state.
  - Byte k occupies bits [8k:8k+7], with bit 8k as the byte MSB.
  - Column c consists of bytes 4c..4c+3, with row 0 first.
- out_valid  output  1  `out` holds a finished result.
- out_ready  input  1  downstream accepts `out`.
- out  output  [0:127]  mixed state, same byte and column layout as `state`.

## Operation
- FSM states: IDLE, BUSY, DONE. Column counter `col`, 2 bits. Working register `st` [0:127].
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: st<=state, col<=0, go to BUSY.
- BUSY
  - in_ready=0, out_valid=0.
  - Each cycle, column `col` of st is replaced in place by its mixed value, then col<=col+1.
  - When col==3, the write is followed by a transition to DONE; col wraps to 0.
- DONE
  - out_valid=1, in_ready=0. `out` is driven from st.
  - On out_ready=1: go to IDLE; `out` keeps its value.
  - While out_ready=0: out_valid and `out` stay stable, with no change until acceptance.
- Column math for a0..a3 (rows 0..3), GF(2^8) with polynomial 0x11b:
  - r0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - r1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - r2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - r3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
  - 2·b = (b<<1)[7:0] ^ (b_msb ? 8'h1b : 8'h00).
  - 3·b = 2·b ^ b.
  - All arithmetic is 8-bit XOR; there is no carry.
- Only one column-mix datapath instance exists; it is muxed by `col`.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.
- No overlap: the next input is accepted only after the output handshake, in IDLE.

## Timing
- Reset (rst_n=0, asynchronous): FSM=IDLE, col=0, st=0, so out=128'h0. in_ready=1, out_valid=0.
- Reset mid-BUSY or mid-DONE aborts the operation. The partial or unaccepted result is discarded, and no out_valid pulse occurs after reset release.
- Let E0 be the edge on which the input handshake occurs.
  - Edges E1..E4 write columns 0..3.
  - out_valid=1 after E4, i.e. 4 cycles after acceptance.
- Minimum block period is 6 cycles: 1 IDLE, 4 BUSY, 1 DONE with out_ready held high.
- in_ready returns to 1 in the cycle after the output handshake.
- All outputs are registered, or decoded directly from FSM state. There is no combinational path from inputs to outputs.
- in_valid held high continuously: exactly one capture per IDLE visit, no double-capture.

## Test plan
- FIPS-197 vector:
  - Stimulus: state = db135345_f20a225c_01010101_c6c6c6c6.
  - Response: out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising exactly 4 cycles after the accept edge.
- Second vector:
  - Stimulus: state = d4d4d4d5_2d26314c_00000000_ffffffff.
  - Response: out = d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 throughout.
  - Response: out and out_valid stay stable, in_ready=0, and no new capture occurs. After out_ready=1, there is one cycle to IDLE, and the next state is captured.
- Async reset:
  - Stimulus: assert rst_n=0 at the second BUSY cycle.
  - Response: outputs go immediately to in_ready=1, out_valid=0, out=0. After release, a fresh vector completes correctly.
- Back-to-back throughput:
  - Stimulus: 100 random states with out_ready=1 and in_valid=1.
  - Response: one result every 6 cycles, each matching a reference model.
- Round-trip:
  - Stimulus: apply the inverse MixColumns transform to each result from 1000 random states.
  - Response: the original state is recovered bit-exactly.
